// File: rtl/pwm_ramp_controller.sv
// Ramp sequencer for an 8-bit PWM core: walks the parallel-load duty value toward a
// commanded target, one clamped step every N PWM periods, updating only at period wrap.
module pwm_ramp_controller #(
    parameter int PERIOD = 255,
    parameter int DUTY_W = 8
) (
    input  logic              pwm_clk,
    input  logic              pwm_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_target,
    input  logic [DUTY_W-1:0] cmd_step,
    input  logic [DUTY_W-1:0] cmd_interval,
    input  logic              abort,
    output logic [DUTY_W-1:0] pwm_duty_in,
    output logic              parallel_enable,
    output logic              busy,
    output logic              done,
    output logic              period_start
);

    localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RAMP = 1'b1;

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_period_cnt;
    logic [DUTY_W-1:0] r_interval_cnt;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] r_target;
    logic [DUTY_W-1:0] r_step;
    logic [DUTY_W-1:0] r_interval;
    logic              r_par_en;
    logic              r_done;

    logic              w_boundary;
    logic              w_accept;
    logic              w_step_due;
    logic [DUTY_W-1:0] w_next_duty;

    // One clamped step toward the target; the extra bit keeps overflow/underflow visible.
    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] duty,
        input logic [DUTY_W-1:0] target,
        input logic [DUTY_W-1:0] step
    );
        logic [DUTY_W:0] sum;
        logic [DUTY_W:0] diff;
        sum  = {1'b0, duty} + {1'b0, step};
        diff = {1'b0, duty} - {1'b0, step};
        if (duty < target) begin
            return (sum >= {1'b0, target}) ? target : sum[DUTY_W-1:0];
        end else if (duty > target) begin
            return (diff[DUTY_W] || (diff[DUTY_W-1:0] <= target)) ? target : diff[DUTY_W-1:0];
        end
        return target;
    endfunction

    function automatic logic [DUTY_W-1:0] zero_as_one(input logic [DUTY_W-1:0] v);
        return (v == '0) ? DUTY_W'(1) : v;
    endfunction

    assign w_boundary  = (r_period_cnt == CNT_LAST);
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_step_due  = (({1'b0, r_interval_cnt} + 1'b1) == {1'b0, r_interval});
    assign w_next_duty = step_toward(r_duty, r_target, r_step);

    assign cmd_ready       = (r_state == S_IDLE) && r_par_en;
    assign busy            = (r_state == S_RAMP);
    assign done            = r_done;
    assign pwm_duty_in     = r_duty;
    assign parallel_enable = r_par_en;
    assign period_start    = (r_period_cnt == '0);

    always_ff @(posedge pwm_clk) begin
        if (!pwm_rst_n) begin
            r_state        <= S_IDLE;
            r_period_cnt   <= '0;
            r_interval_cnt <= '0;
            r_duty         <= '0;
            r_target       <= '0;
            r_step         <= '0;
            r_interval     <= '0;
            r_par_en       <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_par_en     <= 1'b1;
            r_done       <= 1'b0;
            r_period_cnt <= w_boundary ? '0 : r_period_cnt + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_target       <= cmd_target;
                        r_step         <= zero_as_one(cmd_step);
                        r_interval     <= zero_as_one(cmd_interval);
                        r_interval_cnt <= '0;
                        if (cmd_target == r_duty) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_RAMP;
                        end
                    end
                end
                S_RAMP: begin
                    // abort beats a coincident boundary: duty freezes where it is
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (w_boundary) begin
                        if (w_step_due) begin
                            r_interval_cnt <= '0;
                            r_duty         <= w_next_duty;
                            if (w_next_duty == r_target) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_interval_cnt <= r_interval_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed bench for pwm_ramp_controller with PERIOD=8: ramps, clamping, abort, busy hold, reset.
module tb_pwm_ramp_controller;

    localparam int PERIOD = 8;

    logic       pwm_clk = 1'b0;
    logic       pwm_rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_target;
    logic [7:0] cmd_step;
    logic [7:0] cmd_interval;
    logic       abort;
    logic [7:0] pwm_duty_in;
    logic       parallel_enable;
    logic       busy;
    logic       done;
    logic       period_start;

    int n_checks = 0;
    int n_errors = 0;

    always #5 pwm_clk = ~pwm_clk;

    pwm_ramp_controller #(.PERIOD(PERIOD), .DUTY_W(8)) dut (
        .pwm_clk        (pwm_clk),
        .pwm_rst_n      (pwm_rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_target     (cmd_target),
        .cmd_step       (cmd_step),
        .cmd_interval   (cmd_interval),
        .abort          (abort),
        .pwm_duty_in    (pwm_duty_in),
        .parallel_enable(parallel_enable),
        .busy           (busy),
        .done           (done),
        .period_start   (period_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pwm_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance to the next period_cnt==0 cycle, bounded by two periods.
    task automatic next_pstart(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!period_start && n < 2 * PERIOD);
        chk({tag, "_pstart"}, 32'(period_start), 32'd1);
    endtask

    task automatic send_cmd(input string tag, input logic [7:0] t, input logic [7:0] s,
                            input logic [7:0] iv);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid    = 1'b1;
        cmd_target   = t;
        cmd_step     = s;
        cmd_interval = iv;
        tick();
        cmd_valid    = 1'b0;
    endtask

    initial begin
        pwm_rst_n    = 1'b0;
        cmd_valid    = 1'b0;
        cmd_target   = 8'd0;
        cmd_step     = 8'd0;
        cmd_interval = 8'd0;
        abort        = 1'b0;
        ticks(2);
        chk("rst_duty",   32'(pwm_duty_in),     32'd0);
        chk("rst_pen",    32'(parallel_enable), 32'd0);
        chk("rst_busy",   32'(busy),            32'd0);
        chk("rst_done",   32'(done),            32'd0);
        chk("rst_ready",  32'(cmd_ready),       32'd0);
        chk("rst_pstart", 32'(period_start),    32'd1);
        pwm_rst_n = 1'b1;
        tick();
        chk("rel_pen",    32'(parallel_enable), 32'd1);
        chk("rel_ready",  32'(cmd_ready),       32'd1);
        chk("rel_pstart", 32'(period_start),    32'd0);

        // 0 -> 10, step 4, every period
        send_cmd("t1", 8'd10, 8'd4, 8'd1);
        chk("t1_busy",  32'(busy),        32'd1);
        chk("t1_nrdy",  32'(cmd_ready),   32'd0);
        chk("t1_duty0", 32'(pwm_duty_in), 32'd0);
        next_pstart("t1a");
        chk("t1_duty4", 32'(pwm_duty_in), 32'd4);
        chk("t1_done4", 32'(done),        32'd0);
        ticks(3);
        chk("t1_hold4", 32'(pwm_duty_in), 32'd4);
        next_pstart("t1b");
        chk("t1_duty8", 32'(pwm_duty_in), 32'd8);
        next_pstart("t1c");
        chk("t1_duty10", 32'(pwm_duty_in), 32'd10);
        chk("t1_done",   32'(done),        32'd1);
        chk("t1_idle",   32'(busy),        32'd0);
        chk("t1_rdy",    32'(cmd_ready),   32'd1);
        tick();
        chk("t1_donepulse", 32'(done), 32'd0);

        // up to 250, then 250 -> 255 with step 10 must clamp, not wrap
        send_cmd("t2a", 8'd250, 8'd240, 8'd1);
        next_pstart("t2a");
        chk("t2_duty250", 32'(pwm_duty_in), 32'd250);
        send_cmd("t2b", 8'd255, 8'd10, 8'd1);
        next_pstart("t2b");
        chk("t2_duty255", 32'(pwm_duty_in), 32'd255);
        chk("t2_done",    32'(done),        32'd1);

        // down to 5, then 5 -> 0 step 3 every 2 periods
        send_cmd("t3a", 8'd5, 8'd250, 8'd1);
        next_pstart("t3a");
        chk("t3_duty5", 32'(pwm_duty_in), 32'd5);
        send_cmd("t3b", 8'd0, 8'd3, 8'd2);
        next_pstart("t3b1");
        chk("t3_b1", 32'(pwm_duty_in), 32'd5);
        next_pstart("t3b2");
        chk("t3_b2", 32'(pwm_duty_in), 32'd2);
        chk("t3_b2done", 32'(done), 32'd0);
        next_pstart("t3b3");
        chk("t3_b3", 32'(pwm_duty_in), 32'd2);
        next_pstart("t3b4");
        chk("t3_b4", 32'(pwm_duty_in), 32'd0);
        chk("t3_b4done", 32'(done), 32'd1);

        // abort coincident with a boundary at duty 3
        send_cmd("t4a", 8'd200, 8'd1, 8'd1);
        for (int k = 1; k <= 3; k++) begin
            next_pstart("t4ramp");
            chk("t4_ramp", 32'(pwm_duty_in), 32'(k));
        end
        ticks(PERIOD - 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_duty",  32'(pwm_duty_in), 32'd3);
        chk("t4_done",  32'(done),        32'd0);
        chk("t4_busy",  32'(busy),        32'd0);
        chk("t4_ready", 32'(cmd_ready),   32'd1);
        next_pstart("t4hold");
        chk("t4_hold", 32'(pwm_duty_in), 32'd3);
        send_cmd("t4b", 8'd6, 8'd3, 8'd1);
        next_pstart("t4b");
        chk("t4_new",     32'(pwm_duty_in), 32'd6);
        chk("t4_newdone", 32'(done),        32'd1);

        // command held during a ramp is not taken until the controller is idle
        send_cmd("t5a", 8'd20, 8'd2, 8'd1);
        cmd_valid  = 1'b1;
        cmd_target = 8'd50;
        tick();
        chk("t5_nrdy", 32'(cmd_ready), 32'd0);
        chk("t5_busy", 32'(busy),      32'd1);
        for (int k = 1; k <= 7; k++) begin
            next_pstart("t5ramp");
            chk("t5_duty", 32'(pwm_duty_in), 32'(6 + 2 * k));
            chk("t5_done", 32'(done),        32'(k == 7));
            chk("t5_rdy",  32'(cmd_ready),   32'(k == 7));
        end
        tick();
        cmd_valid = 1'b0;
        chk("t5_acc_busy", 32'(busy),        32'd1);
        chk("t5_acc_duty", 32'(pwm_duty_in), 32'd20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_ab_busy", 32'(busy),        32'd0);
        chk("t5_ab_duty", 32'(pwm_duty_in), 32'd20);
        send_cmd("t5b", 8'd20, 8'd5, 8'd1);
        chk("t5_eq_done", 32'(done),      32'd1);
        chk("t5_eq_busy", 32'(busy),      32'd0);
        chk("t5_eq_rdy",  32'(cmd_ready), 32'd1);
        tick();
        chk("t5_eq_pulse", 32'(done), 32'd0);

        // reset mid-ramp at duty 40, then zero step/interval act as 1
        send_cmd("t6a", 8'd100, 8'd20, 8'd1);
        next_pstart("t6a");
        chk("t6_duty40", 32'(pwm_duty_in), 32'd40);
        ticks(2);
        pwm_rst_n = 1'b0;
        tick();
        chk("t6_duty",   32'(pwm_duty_in),     32'd0);
        chk("t6_busy",   32'(busy),            32'd0);
        chk("t6_pen",    32'(parallel_enable), 32'd0);
        chk("t6_pstart", 32'(period_start),    32'd1);
        chk("t6_ready",  32'(cmd_ready),       32'd0);
        pwm_rst_n = 1'b1;
        tick();
        next_pstart("t6sync");
        ticks(PERIOD - 1);
        send_cmd("t6b", 8'd3, 8'd0, 8'd0);
        chk("t6_bnd_busy", 32'(busy),        32'd1);
        chk("t6_bnd_duty", 32'(pwm_duty_in), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            next_pstart("t6ramp");
            chk("t6_ramp", 32'(pwm_duty_in), 32'(k));
            chk("t6_done", 32'(done),        32'(k == 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
